// File: rtl/ext_pipe.sv
// Registered immediate-extension stage: computes sign/zero/lui/branch/jump/shift
// results at accept time and holds them in a 2-entry valid/ready FIFO.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [JIDX_W-1:0] in_imm,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ext,
  output logic              out_err
);

  // Handshake: a beat transfers on a side when its valid and ready are both
  // high at the rising edge; in_ready depends only on the entry count.
  localparam logic [2:0] OP_SIGN   = 3'b000;
  localparam logic [2:0] OP_ZERO   = 3'b001;
  localparam logic [2:0] OP_LUI    = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_JUMP   = 3'b100;
  localparam logic [2:0] OP_SSHIFT = 3'b101;

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] calc_ext;
  logic              calc_err;

  logic [DATA_W-1:0] ext_mem [2];
  logic              err_mem [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              accept;
  logic              pop;

  assign imm  = in_imm[IMM_W-1:0];
  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign pc4  = in_pc + DATA_W'(4);

  always_comb begin
    calc_ext = '0;
    calc_err = 1'b0;
    case (in_op)
      OP_SIGN:   calc_ext = sext;
      OP_ZERO:   calc_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      OP_LUI:    calc_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      OP_BRANCH: calc_ext = pc4 + (sext << 2);
      OP_JUMP:   calc_ext = {pc4[DATA_W-1:JIDX_W+2], in_imm, 2'b00};
      OP_SSHIFT: calc_ext = sext << 2;
      default:   calc_err = 1'b1;
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_ext   = ext_mem[rd_ptr];
  assign out_err   = err_mem[rd_ptr];
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ext_mem[i] <= '0;
        err_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (accept) begin
        ext_mem[wr_ptr] <= calc_ext;
        err_mem[wr_ptr] <= calc_err;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Randomized and directed bench for ext_pipe; results are predicted with plain
// integer arithmetic and a FIFO queue of expected head entries.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] in_imm = '0;
  logic [2:0]  in_op = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ext;
  logic        out_err;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [25:0] in_imm64 = '0;
  logic [2:0]  in_op64 = '0;
  logic [63:0] in_pc64 = '0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [63:0] out_ext64;
  logic        out_err64;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];

  ext_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ext(out_ext), .out_err(out_err)
  );

  ext_pipe #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_imm(in_imm64), .in_op(in_op64),
    .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready64),
    .out_ext(out_ext64), .out_err(out_err64)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {err, ext} from the op rules using 64-bit integer arithmetic.
  function automatic logic [32:0] ref_ext(input logic [25:0] jidx, input logic [2:0] op,
                                          input logic [31:0] pc);
    longint imm, s, pc4, r;
    logic   err;
    err = 1'b0;
    imm = longint'(jidx) & 'hFFFF;
    s   = (imm >= 32768) ? imm - 65536 : imm;
    pc4 = longint'(pc) + 4;
    case (op)
      3'd0: r = s;
      3'd1: r = imm;
      3'd2: r = imm * 65536;
      3'd3: r = pc4 + s * 4;
      3'd4: r = (pc4 & 'hF000_0000) | (longint'(jidx) * 4);
      3'd5: r = s * 4;
      default: begin r = 0; err = 1'b1; end
    endcase
    return {err, r[31:0]};
  endfunction

  // Called at a falling edge: check outputs against the model, drive the next
  // inputs, advance the model by the coming rising edge, then wait one cycle.
  task automatic cycle(input logic v, input logic [25:0] imm, input logic [2:0] op,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    logic acc;
    check("in_ready", in_ready, exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_ext", out_ext, exp_q[0][31:0]);
      check("out_err", out_err, exp_q[0][32]);
    end
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    acc = v && (exp_q.size() < 2);
    if (fl) exp_q.delete();
    else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_ext(imm, op, pc));
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, 3'd0, '0, rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ext", out_ext, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    reset = 1'b0;

    // Wide instance: sign and lui with DATA_W=64.
    in_valid64 = 1'b1; in_imm64 = 26'h8000; in_op64 = 3'd0;
    @(negedge clk);
    check("w64_sign", out_ext64, 64'hFFFF_FFFF_FFFF_8000);
    in_op64 = 3'd2; out_ready64 = 1'b1;
    @(negedge clk);
    check("w64_lui", out_ext64, 64'h8000_0000_0000_0000);
    check("w64_err", out_err64, 1'b0);
    in_valid64 = 1'b0;

    // Op sweep: each result must appear one cycle after its accept.
    for (int op = 0; op < 6; op++) begin
      cycle(1'b1, (op == 4) ? 26'h3FF_FFFF : 26'h8001, 3'(op), 32'h0000_3000, 1'b0, 1'b0);
      check("sweep_val", out_ext,
            (op == 0) ? 32'hFFFF_8001 : (op == 1) ? 32'h0000_8001 : (op == 2) ? 32'h8001_0000 :
            (op == 3) ? 32'hFFFE_3008 : (op == 4) ? 32'h0FFF_FFFC : 32'hFFFE_0004);
      idle(1'b1);
    end
    cycle(1'b1, 26'h0001, 3'd3, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap", out_ext, 32'h0000_0004);
    idle(1'b1);
    cycle(1'b1, 26'h1234, 3'd6, 32'h0, 1'b0, 1'b0);
    check("illegal_err", out_err, 1'b1);
    idle(1'b1);

    // Backpressure: third offer refused until a pop frees a slot.
    cycle(1'b1, 26'h0011, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 26'h0022, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 26'h0033, 3'd1, 32'h0, 1'b0, 1'b0);
    check("bp_full", in_ready, 1'b0);
    cycle(1'b1, 26'h0033, 3'd1, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 26'h0033, 3'd1, 32'h0, 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    // Streaming at count 1.
    cycle(1'b1, 26'h0100, 3'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 26'(i * 7 + 1), 3'd0, 32'h0, 1'b1, 1'b0);
    check("stream_cnt1", {in_ready, out_valid}, 2'b11);
    idle(1'b1);

    // Flush with a same-cycle offer.
    cycle(1'b1, 26'h0AAA, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 26'h0BBB, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 26'h0CCC, 3'd1, 32'h0, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    flush = 1'b0;

    // Asynchronous reset between clock edges.
    cycle(1'b1, 26'h0123, 3'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 26'h0456, 3'd0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_ext", out_ext, 32'h0);
    exp_q.delete();
    #1 reset = 1'b0;
    @(negedge clk);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 26'($urandom()), 3'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
